l2_tlb: RTL
===========

// Module: l2_tlb
// PURPOSE
//  Shared, fully-associative second-level TLB (JTLB) that backs the L1 I-TLB and L1 D-TLB refill FSMs.
//  Provides two same-cycle combinational lookup ports, CP0 TLBWI/TLBWR/TLBP/TLBR execution and the Random/Wired counter.
//  Raises fence_tlb so that L1 TLBs flush after any mapping or ASID change.
//  Sits between CP0/exception commit logic and the L1 TLBs; entry type is tlb_entry from defines.vh
//  (VPN2[31:13], ASID[7:0], G, PFN0/C0/D0/V0, PFN1/C1/D1/V1).
// PARAMETERS
//  NR_TLB_ENTRY  16  number of entries, power of two, >=2; IW = $clog2(NR_TLB_ENTRY)
// PORTS
//  clk              in   1       clock, all state on posedge
//  rst              in   1       asynchronous, active-high reset
//  asid             in   8       current EntryHi.ASID
//  dtlb_vpn2        in   19      D-side lookup VPN2 (va[31:13])
//  dtlb_found       out  1       D-side hit, combinational
//  dtlb_entry       out  tlb_entry  D-side matching entry, combinational
//  itlb_vpn2        in   19      I-side lookup VPN2
//  itlb_found       out  1       I-side hit, combinational
//  itlb_entry       out  tlb_entry  I-side matching entry, combinational
//  tlbwi            in   1       commit pulse: write w_entry at cp0_index
//  tlbwr            in   1       commit pulse: write w_entry at random
//  tlbp             in   1       commit pulse: probe {cp0_vpn2, asid}
//  tlbr             in   1       commit pulse: read entry at cp0_index
//  cp0_index        in   IW      Index register
//  cp0_vpn2         in   19      EntryHi.VPN2 for probe
//  w_entry          in   tlb_entry  data for TLBWI/TLBWR
//  wired_we         in   1       CP0 Wired write strobe
//  wired_wdata      in   IW      new Wired value
//  random           out  IW      current Random register
//  tlbp_valid       out  1       1-cycle pulse, probe result valid
//  tlbp_miss        out  1       probe missed (Index.P)
//  tlbp_index       out  IW      probe hit index
//  tlbr_valid       out  1       1-cycle pulse, tlbr_entry valid
//  tlbr_entry       out  tlb_entry  registered read data
//  fence_tlb        out  1       L1 TLB flush request, level
//  fence_ack        in   1       L1 consumed fence (E_ready_go)
// BEHAVIOUR
//  Reset: all entries all-zero, wired=0, random=NR-1, tlbp_valid/tlbp_miss/tlbp_index=0,
//   tlbr_valid=0, tlbr_entry=0, fence_tlb=0, asid shadow=0. found/entry outputs follow the array.
//  Match(e,v,a): e.VPN2==v && (e.G || e.ASID==a). Lookup ports are purely combinational, 0 extra cycles.
//   Multiple hits -> lowest index wins. Miss -> found=0, entry=0.
//  Writes: tlbwi has priority over tlbwr if both are asserted; the array is updated at the edge.
//   Lookups see the new value from the following cycle. TLBWR uses the random value present in the cycle of the pulse.
//  Random: each cycle, if random<=wired or random==0 then random<=NR-1 else random<=random-1.
//   wired_we: wired<=wired_wdata, random<=NR-1 (overrides decrement). wired_wdata>=NR: random held at NR-1.
//  TLBP: result registered; tlbp_valid=1 the cycle after the pulse.
//   tlbp_miss=!hit; tlbp_index=lowest matching index on hit, else 0. Probe sees pre-write array if same-cycle write.
//  TLBR: tlbr_entry<=entries[cp0_index], tlbr_valid=1 next cycle; same-cycle write to that index returns old data.
//  fence_tlb: set on tlbwi|tlbwr, or when asid != asid shadow (shadow updated every cycle).
//   Cleared by fence_ack when not simultaneously set; set wins over ack.
//  Reset mid-operation: pending fence, probe and read results are discarded; array returns to zero.
// TESTING
//  1. TLBWI idx3 {VPN2=0x00400,ASID=5,G=0,V0=1,PFN0=0x1234}, asid=5, dtlb_vpn2=0x00400 -> dtlb_found=1 next cycle, PFN0=0x1234; asid=6 -> found=0.
//  2. Same entry G=1 at idx3 and G=1 dup at idx7 -> itlb_found=1, itlb_entry equals idx3 for any asid.
//  3. wired_we 4 -> random=15,14..4,15,...; TLBWR when random=9 -> entry 9 written, fence_tlb=1 until fence_ack.
//  4. TLBP {0x00400,5} after test1 -> tlbp_valid pulse, miss=0, index=3; TLBP 0x7FFFF -> miss=1, index=0.
//  5. TLBR idx3 with simultaneous TLBWI idx3 new data -> tlbr_entry=old data; second TLBR -> new data.
//  6. Reset asserted one cycle after TLBWI: fence_tlb=0, random=15, lookups miss for non-zero VPN2.

Source files
------------

// File: rtl/l2_tlb_if.sv
// Entry type shared by the JTLB and its clients, plus the bundle of lookup,
// CP0 command and fence signals between the JTLB and its clients.
package l2_tlb_pkg;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

endpackage

interface l2_tlb_if
    import l2_tlb_pkg::*;
#(
    parameter int NR_TLB_ENTRY = 16
) ();
    localparam int IW = $clog2(NR_TLB_ENTRY);

    logic [7:0]    asid;
    logic [18:0]   dtlb_vpn2;
    logic          dtlb_found;
    tlb_entry_t    dtlb_entry;
    logic [18:0]   itlb_vpn2;
    logic          itlb_found;
    tlb_entry_t    itlb_entry;
    logic          tlbwi;
    logic          tlbwr;
    logic          tlbp;
    logic          tlbr;
    logic [IW-1:0] cp0_index;
    logic [18:0]   cp0_vpn2;
    tlb_entry_t    w_entry;
    logic          wired_we;
    logic [IW-1:0] wired_wdata;
    logic [IW-1:0] random;
    logic          tlbp_valid;
    logic          tlbp_miss;
    logic [IW-1:0] tlbp_index;
    logic          tlbr_valid;
    tlb_entry_t    tlbr_entry;
    logic          fence_tlb;
    logic          fence_ack;

    modport slave (
        input  asid, dtlb_vpn2, itlb_vpn2, tlbwi, tlbwr, tlbp, tlbr,
               cp0_index, cp0_vpn2, w_entry, wired_we, wired_wdata, fence_ack,
        output dtlb_found, dtlb_entry, itlb_found, itlb_entry, random,
               tlbp_valid, tlbp_miss, tlbp_index, tlbr_valid, tlbr_entry, fence_tlb
    );

    modport master (
        output asid, dtlb_vpn2, itlb_vpn2, tlbwi, tlbwr, tlbp, tlbr,
               cp0_index, cp0_vpn2, w_entry, wired_we, wired_wdata, fence_ack,
        input  dtlb_found, dtlb_entry, itlb_found, itlb_entry, random,
               tlbp_valid, tlbp_miss, tlbp_index, tlbr_valid, tlbr_entry, fence_tlb
    );

endinterface

// File: rtl/l2_tlb.sv
// Shared fully-associative JTLB: two combinational lookup ports, CP0 TLBWI/TLBWR/
// TLBP/TLBR execution, the Random/Wired counter and the L1 flush request.
module l2_tlb
    import l2_tlb_pkg::*;
#(
    parameter int NR_TLB_ENTRY = 16
) (
    input  logic    clk,
    input  logic    rst,
    l2_tlb_if.slave bus
);
    localparam int            IW         = $clog2(NR_TLB_ENTRY);
    localparam int            EW         = $bits(tlb_entry_t);
    localparam logic [IW-1:0] RAND_TOP   = IW'(NR_TLB_ENTRY - 1);
    localparam logic [IW-1:0] IDX_ONE    = IW'(1'b1);
    localparam logic [IW-1:0] IDX_ZERO   = {IW{1'b0}};
    localparam tlb_entry_t    ENTRY_ZERO = tlb_entry_t'({EW{1'b0}});

    tlb_entry_t        entries_q [NR_TLB_ENTRY];
    tlb_entry_t        entries_d [NR_TLB_ENTRY];
    logic [IW-1:0]     random_q, random_d;
    logic [IW-1:0]     wired_q, wired_d;
    logic              tlbp_valid_q, tlbp_valid_d;
    logic              tlbp_miss_q, tlbp_miss_d;
    logic [IW-1:0]     tlbp_index_q, tlbp_index_d;
    logic              tlbr_valid_q, tlbr_valid_d;
    tlb_entry_t        tlbr_entry_q, tlbr_entry_d;
    logic              fence_q, fence_d;
    logic [7:0]        asid_shadow_q, asid_shadow_d;

    logic [NR_TLB_ENTRY-1:0] d_hits, i_hits, p_hits;
    logic [IW:0]             d_sel, i_sel, p_sel;
    logic                    fence_set;

    function automatic logic entry_match(input tlb_entry_t e, input logic [18:0] vpn2,
                                         input logic [7:0] asid);
        return (e.vpn2 == vpn2) && (e.g || (e.asid == asid));
    endfunction

    // Returns {hit, index}; scanning downwards leaves the lowest matching index.
    function automatic logic [IW:0] first_hit(input logic [NR_TLB_ENTRY-1:0] hits);
        logic [IW:0] r;
        r = {(IW+1){1'b0}};
        for (int i = NR_TLB_ENTRY - 1; i >= 0; i--) begin
            r = hits[i] ? {1'b1, i[IW-1:0]} : r;
        end
        return r;
    endfunction

    // Per-entry match vectors for both lookup ports and the probe.
    always_comb begin
        for (int i = 0; i < NR_TLB_ENTRY; i++) begin
            d_hits[i] = entry_match(entries_q[i], bus.dtlb_vpn2, bus.asid);
            i_hits[i] = entry_match(entries_q[i], bus.itlb_vpn2, bus.asid);
            p_hits[i] = entry_match(entries_q[i], bus.cp0_vpn2, bus.asid);
        end
    end

    assign d_sel = first_hit(d_hits);
    assign i_sel = first_hit(i_hits);
    assign p_sel = first_hit(p_hits);

    assign bus.dtlb_found = d_sel[IW];
    assign bus.dtlb_entry = d_sel[IW] ? entries_q[d_sel[IW-1:0]] : ENTRY_ZERO;
    assign bus.itlb_found = i_sel[IW];
    assign bus.itlb_entry = i_sel[IW] ? entries_q[i_sel[IW-1:0]] : ENTRY_ZERO;

    // Next-state for the array, Random/Wired, probe/read results and fence.
    always_comb begin
        entries_d = entries_q;
        if (bus.tlbwi) begin
            entries_d[bus.cp0_index] = bus.w_entry;
        end else if (bus.tlbwr) begin
            entries_d[random_q] = bus.w_entry;
        end else begin
            entries_d = entries_q;
        end

        if (bus.wired_we) begin
            wired_d  = bus.wired_wdata;
            random_d = RAND_TOP;
        end else if ((random_q <= wired_q) || (random_q == IDX_ZERO)) begin
            wired_d  = wired_q;
            random_d = RAND_TOP;
        end else begin
            wired_d  = wired_q;
            random_d = random_q - IDX_ONE;
        end

        // Probe and read sample the array before this cycle's write lands.
        tlbp_valid_d = bus.tlbp;
        if (bus.tlbp) begin
            tlbp_miss_d  = ~p_sel[IW];
            tlbp_index_d = p_sel[IW-1:0];
        end else begin
            tlbp_miss_d  = tlbp_miss_q;
            tlbp_index_d = tlbp_index_q;
        end

        tlbr_valid_d = bus.tlbr;
        if (bus.tlbr) begin
            tlbr_entry_d = entries_q[bus.cp0_index];
        end else begin
            tlbr_entry_d = tlbr_entry_q;
        end

        asid_shadow_d = bus.asid;
        fence_set     = bus.tlbwi | bus.tlbwr | (bus.asid != asid_shadow_q);
        if (fence_set) begin
            fence_d = 1'b1;
        end else if (bus.fence_ack) begin
            fence_d = 1'b0;
        end else begin
            fence_d = fence_q;
        end
    end

    // State registers; reset discards pending probe/read/fence and clears the array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NR_TLB_ENTRY; i++) begin
                entries_q[i] <= ENTRY_ZERO;
            end
            random_q      <= RAND_TOP;
            wired_q       <= IDX_ZERO;
            tlbp_valid_q  <= 1'b0;
            tlbp_miss_q   <= 1'b0;
            tlbp_index_q  <= IDX_ZERO;
            tlbr_valid_q  <= 1'b0;
            tlbr_entry_q  <= ENTRY_ZERO;
            fence_q       <= 1'b0;
            asid_shadow_q <= 8'h00;
        end else begin
            for (int i = 0; i < NR_TLB_ENTRY; i++) begin
                entries_q[i] <= entries_d[i];
            end
            random_q      <= random_d;
            wired_q       <= wired_d;
            tlbp_valid_q  <= tlbp_valid_d;
            tlbp_miss_q   <= tlbp_miss_d;
            tlbp_index_q  <= tlbp_index_d;
            tlbr_valid_q  <= tlbr_valid_d;
            tlbr_entry_q  <= tlbr_entry_d;
            fence_q       <= fence_d;
            asid_shadow_q <= asid_shadow_d;
        end
    end

    assign bus.random     = random_q;
    assign bus.tlbp_valid = tlbp_valid_q;
    assign bus.tlbp_miss  = tlbp_miss_q;
    assign bus.tlbp_index = tlbp_index_q;
    assign bus.tlbr_valid = tlbr_valid_q;
    assign bus.tlbr_entry = tlbr_entry_q;
    assign bus.fence_tlb  = fence_q;

endmodule
